// File: rtl/bp_pkg.sv
// Shared definitions for the branch history table predictor:
// 2-bit counter encodings, table init value, FSM state type and
// the saturating counter update function.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] BP_INIT_VAL = WNT;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_e;

    // Saturating step: toward ST on taken, toward SNT on not-taken.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == ST) ? ST : ctr + 2'd1;
        end else begin
            nxt = (ctr == SNT) ? SNT : ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_table.sv
// 2^IDX_W x 2-bit counter storage. Combinational read for the fetch
// prediction, combinational read of the resolving entry so the parent can
// form the saturated update, and one synchronous write port. No reset: the
// parent sweeps every entry after reset before predictions go live.
module bp_table #(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_data,
    input  logic [IDX_W-1:0] upd_idx,
    output logic [1:0]       upd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [1:0]       wr_data
);

    logic [1:0] mem [1 << IDX_W];

    assign rd_data  = mem[rd_idx];
    assign upd_data = mem[upd_idx];

    // Single synchronous write; a same-cycle read sees the old value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Branch history table predictor: 2-bit saturating counters indexed by PC,
// initialised by a hardware sweep after reset, trained from EX resolution,
// with saturating branch / mispredict statistics.
// Optional feature: define BP_GSHARE_EN to XOR a non-speculative global
// history register into the table index.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int IDX_W  = 6,
    parameter int PC_LSB = 2,
    parameter int HIST_W = 6,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    input  logic             if_valid,
    output logic             predict_pcsrc,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             res_valid,
    input  logic [IDX_W-1:0] res_idx,
    input  logic             res_taken,
    input  logic             res_update,
    output logic             ready,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    if (HIST_W > IDX_W || HIST_W < 2) begin : g_bad_hist
        $error("HIST_W must be in 2..IDX_W");
    end

    bp_state_e        state;
    logic [IDX_W-1:0] init_ptr;
    logic [IDX_W-1:0] fetch_idx;
    logic [1:0]       rd_data;
    logic [1:0]       upd_data;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       wr_data;
    logic             train;
    logic             unused_pc;

    // Only the index slice of if_pc is used.
    assign unused_pc = ^if_pc;

    assign train = (state == RUN) && res_valid;

`ifdef BP_GSHARE_EN
    logic [HIST_W-1:0] ghr;

    // History shifts in resolved outcomes only (newest in LSB).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (train) begin
            ghr <= {ghr[HIST_W-2:0], res_taken};
        end
    end

    assign fetch_idx = if_pc[PC_LSB +: IDX_W] ^ IDX_W'(ghr);
`else
    assign fetch_idx = if_pc[PC_LSB +: IDX_W];
`endif

    // Predictions and index are held at zero until the table is swept.
    assign ready         = (state == RUN);
    assign pred_idx      = ready ? fetch_idx : '0;
    assign predict_pcsrc = ready & if_valid & rd_data[1];

    // Write port: init sweep owns it in INIT, training owns it in RUN.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = res_idx;
        wr_data = ctr_next(upd_data, res_taken);
        if (state == INIT) begin
            wr_en   = 1'b1;
            wr_idx  = init_ptr;
            wr_data = BP_INIT_VAL;
        end else if (res_valid) begin
            wr_en   = 1'b1;
        end
    end

    bp_table #(
        .IDX_W(IDX_W)
    ) u_table (
        .clk     (clk),
        .rd_idx  (fetch_idx),
        .rd_data (rd_data),
        .upd_idx (res_idx),
        .upd_data(upd_data),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data)
    );

    // Init sweep: one entry per cycle, RUN once the last entry is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_ptr <= '0;
        end else if (state == INIT) begin
            init_ptr <= init_ptr + 1'b1;
            if (init_ptr == {IDX_W{1'b1}}) begin
                state <= RUN;
            end
        end
    end

    // Saturating statistics, frozen during INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (train) begin
            if (branch_cnt != {CNT_W{1'b1}}) begin
                branch_cnt <= branch_cnt + 1'b1;
            end
            if (res_update && mispred_cnt != {CNT_W{1'b1}}) begin
                mispred_cnt <= mispred_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht (default build, no gshare).
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        predict_pcsrc;
    logic [5:0]  pred_idx;
    logic        res_valid;
    logic [5:0]  res_idx;
    logic        res_taken;
    logic        res_update;
    logic        ready;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_predictor_bht dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_pc        (if_pc),
        .if_valid     (if_valid),
        .predict_pcsrc(predict_pcsrc),
        .pred_idx     (pred_idx),
        .res_valid    (res_valid),
        .res_idx      (res_idx),
        .res_taken    (res_taken),
        .res_update   (res_update),
        .ready        (ready),
        .branch_cnt   (branch_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        rv;
        logic [5:0]  ri;
        logic        rt;
        logic        ru;
        logic        ep;
        logic [5:0]  ei;
        int          eb;
        int          em;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int cyc;
        // pc, valid, res_valid, res_idx, res_taken, res_update, exp pred, exp idx, exp branch, exp mispred
        // Outputs are checked before the edge, so counts and predictions
        // reflect state prior to this vector's own update.
        vecs[0]  = '{32'h100, 1, 0, 6'd0, 0, 1, 0, 6'd0,  0, 0};
        vecs[1]  = '{32'h100, 1, 1, 6'd0, 1, 1, 0, 6'd0,  0, 0};
        vecs[2]  = '{32'h100, 1, 1, 6'd0, 1, 0, 1, 6'd0,  1, 1};
        vecs[3]  = '{32'h100, 1, 1, 6'd0, 0, 0, 1, 6'd0,  2, 1};
        vecs[4]  = '{32'h100, 1, 0, 6'd0, 0, 0, 1, 6'd0,  3, 1};
        vecs[5]  = '{32'h100, 0, 0, 6'd0, 0, 0, 0, 6'd0,  3, 1};
        vecs[6]  = '{32'h014, 1, 1, 6'd5, 0, 0, 0, 6'd5,  3, 1};
        vecs[7]  = '{32'h014, 1, 1, 6'd5, 0, 1, 0, 6'd5,  4, 1};
        vecs[8]  = '{32'h014, 1, 1, 6'd5, 0, 0, 0, 6'd5,  5, 2};
        vecs[9]  = '{32'h014, 1, 1, 6'd5, 0, 0, 0, 6'd5,  6, 2};
        vecs[10] = '{32'h014, 1, 1, 6'd5, 0, 0, 0, 6'd5,  7, 2};
        vecs[11] = '{32'h014, 1, 1, 6'd5, 1, 1, 0, 6'd5,  8, 2};
        vecs[12] = '{32'h014, 1, 0, 6'd5, 0, 1, 0, 6'd5,  9, 3};
        vecs[13] = '{32'h00C, 1, 1, 6'd3, 1, 0, 0, 6'd3,  9, 3};
        vecs[14] = '{32'h00C, 1, 0, 6'd0, 0, 0, 1, 6'd3, 10, 3};
        vecs[15] = '{32'h0FC, 1, 0, 6'd0, 0, 0, 0, 6'd63, 10, 3};
        vecs[16] = '{32'hFFFFFFFC, 1, 0, 6'd0, 0, 0, 0, 6'd63, 10, 3};

        rst_n = 1'b0;
        if_pc = 32'h100;
        if_valid = 1'b1;
        res_valid = 1'b1;
        res_idx = 6'd0;
        res_taken = 1'b1;
        res_update = 1'b1;

        #1;
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_pred", {31'd0, predict_pcsrc}, 32'd0);
        check("reset_idx", {26'd0, pred_idx}, 32'd0);
        check("reset_bcnt", branch_cnt, 32'd0);
        check("reset_mcnt", mispred_cnt, 32'd0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Init sweep with res_* held active: must be ignored.
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            check("init_ready", {31'd0, ready}, (i == 63) ? 32'd1 : 32'd0);
            if (i < 63) begin
                check("init_pred", {31'd0, predict_pcsrc}, 32'd0);
                check("init_idx", {26'd0, pred_idx}, 32'd0);
            end
            check("init_bcnt", branch_cnt, 32'd0);
        end

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if_pc      = vecs[i].pc;
            if_valid   = vecs[i].valid;
            res_valid  = vecs[i].rv;
            res_idx    = vecs[i].ri;
            res_taken  = vecs[i].rt;
            res_update = vecs[i].ru;
            #1;
            check($sformatf("v%0d_pred", i), {31'd0, predict_pcsrc}, {31'd0, vecs[i].ep});
            check($sformatf("v%0d_idx", i), {26'd0, pred_idx}, {26'd0, vecs[i].ei});
            check($sformatf("v%0d_bcnt", i), branch_cnt, vecs[i].eb);
            check($sformatf("v%0d_mcnt", i), mispred_cnt, vecs[i].em);
        end

        // Trained idx 0 (counter 10) predicts taken before reset.
        @(negedge clk);
        if_pc = 32'h100;
        if_valid = 1'b1;
        res_valid = 1'b0;
        res_update = 1'b0;
        #1;
        check("pre_rst_pred", {31'd0, predict_pcsrc}, 32'd1);

        // Mid-run reset: everything drops immediately.
        @(negedge clk);
        rst_n = 1'b0;
        if_pc = 32'h104;
        #1;
        check("midrst_ready", {31'd0, ready}, 32'd0);
        check("midrst_pred", {31'd0, predict_pcsrc}, 32'd0);
        check("midrst_idx", {26'd0, pred_idx}, 32'd0);
        check("midrst_bcnt", branch_cnt, 32'd0);
        check("midrst_mcnt", mispred_cnt, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        if_pc = 32'h100;
        cyc = 0;
        while (!ready && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("reinit_cycles", cyc, 32'd64);
        check("reinit_pred", {31'd0, predict_pcsrc}, 32'd0);
        check("reinit_idx", {26'd0, pred_idx}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
